hazard_ctrl_pipe: RTL and testbench

Carries main-decoder control outputs from Decode through the Execute, Memory and Writeback pipeline registers. Computes hazard controls for the 5-stage RISC-V pipeline:
- branch resolution (PCSrcE)
- load-use stall
- D/E flushes
- E-stage operand forwarding selects

It sits between the combinational main/ALU decoders (D stage) and the datapath's pipeline registers, PC and forwarding muxes.

---
 rtl/hazard_ctrl_pipe.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: carries decoder control bits through the E/M/W pipeline registers
// and derives branch redirect, load-use stall, D/E flushes and E-stage forwarding selects.
module hazard_ctrl_pipe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       RegWriteD,
   input  logic       MemWriteD,
   input  logic       BranchD,
   input  logic       ALUSrcD,
   input  logic [1:0] ResultSrcD,
   input  logic [2:0] ALUControlD,
   input  logic [4:0] Rs1D,
   input  logic [4:0] Rs2D,
   input  logic [4:0] RdD,
   input  logic       ZeroE,
   output logic       ALUSrcE,
   output logic [2:0] ALUControlE,
   output logic       MemWriteM,
   output logic       RegWriteM,
   output logic [4:0] RdM,
   output logic       RegWriteW,
   output logic [1:0] ResultSrcW,
   output logic [4:0] RdW,
   output logic       PCSrcE,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       FlushE
);

   logic       regWriteE;
   logic       memWriteE;
   logic       branchE;
   logic [1:0] resultSrcE;
   logic [4:0] rs1E;
   logic [4:0] rs2E;
   logic [4:0] rdE;
   logic [1:0] resultSrcM;
   logic       lwStall;

   // Non-writing instructions carry ResultSrc=00 so a don't-care decoder field never enters the pipe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regWriteE   <= 1'b0;
         resultSrcE  <= 2'b00;
         memWriteE   <= 1'b0;
         branchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ALUControlE <= 3'b000;
         rs1E        <= 5'd0;
         rs2E        <= 5'd0;
         rdE         <= 5'd0;
      end else if (FlushE) begin
         regWriteE   <= 1'b0;
         resultSrcE  <= 2'b00;
         memWriteE   <= 1'b0;
         branchE     <= 1'b0;
         ALUSrcE     <= 1'b0;
         ALUControlE <= 3'b000;
         rs1E        <= 5'd0;
         rs2E        <= 5'd0;
         rdE         <= 5'd0;
      end else begin
         regWriteE   <= RegWriteD;
         resultSrcE  <= RegWriteD ? ResultSrcD : 2'b00;
         memWriteE   <= MemWriteD;
         branchE     <= BranchD;
         ALUSrcE     <= ALUSrcD;
         ALUControlE <= ALUControlD;
         rs1E        <= Rs1D;
         rs2E        <= Rs2D;
         rdE         <= RdD;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWriteM  <= 1'b0;
         resultSrcM <= 2'b00;
         MemWriteM  <= 1'b0;
         RdM        <= 5'd0;
         RegWriteW  <= 1'b0;
         ResultSrcW <= 2'b00;
         RdW        <= 5'd0;
      end else begin
         RegWriteM  <= regWriteE;
         resultSrcM <= resultSrcE;
         MemWriteM  <= memWriteE;
         RdM        <= rdE;
         RegWriteW  <= RegWriteM;
         ResultSrcW <= resultSrcM;
         RdW        <= RdM;
      end
   end

   // M is checked before W so the youngest producer of a register wins
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (rs1E != 5'd0 && RegWriteM && RdM == rs1E)
         ForwardAE = 2'b10;
      else if (rs1E != 5'd0 && RegWriteW && RdW == rs1E)
         ForwardAE = 2'b01;
      if (rs2E != 5'd0 && RegWriteM && RdM == rs2E)
         ForwardBE = 2'b10;
      else if (rs2E != 5'd0 && RegWriteW && RdW == rs2E)
         ForwardBE = 2'b01;
   end

   always_comb begin
      lwStall = 1'b0;
      if (resultSrcE == 2'b01 && rdE != 5'd0 && (Rs1D == rdE || Rs2D == rdE))
         lwStall = 1'b1;
      PCSrcE = branchE & ZeroE;
      StallF = lwStall;
      StallD = lwStall;
      FlushD = PCSrcE;
      FlushE = lwStall | PCSrcE;
   end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// tb_hazard_ctrl_pipe: directed hazard scenarios plus a randomized run against an
// instruction-history reference model of the control pipe.
module tb_hazard_ctrl_pipe;

   logic       clk;
   logic       rst_n;
   logic       RegWriteD, MemWriteD, BranchD, ALUSrcD;
   logic [1:0] ResultSrcD;
   logic [2:0] ALUControlD;
   logic [4:0] Rs1D, Rs2D, RdD;
   logic       ZeroE;
   logic       ALUSrcE;
   logic [2:0] ALUControlE;
   logic       MemWriteM, RegWriteM;
   logic [4:0] RdM;
   logic       RegWriteW;
   logic [1:0] ResultSrcW;
   logic [4:0] RdW;
   logic       PCSrcE;
   logic [1:0] ForwardAE, ForwardBE;
   logic       StallF, StallD, FlushD, FlushE;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic       regWrite;
      logic [1:0] resultSrc;
      logic       memWrite;
      logic       branch;
      logic       aluSrc;
      logic [2:0] aluCtl;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } instr_t;

   hazard_ctrl_pipe dut (
      .clk(clk), .rst_n(rst_n),
      .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .ALUSrcD(ALUSrcD),
      .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ZeroE(ZeroE),
      .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
      .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .RdM(RdM),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
      .PCSrcE(PCSrcE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic setD(input logic rw, input logic mw, input logic br, input logic as,
                       input logic [1:0] rs, input logic [2:0] ac,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
      RegWriteD = rw; MemWriteD = mw; BranchD = br; ALUSrcD = as;
      ResultSrcD = rs; ALUControlD = ac; Rs1D = r1; Rs2D = r2; RdD = rd;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic flushPipe();
      setD(0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0);
      ZeroE = 1'b0;
      repeat (3) cyc();
   endtask

   task automatic test_reset();
      setD(1, 0, 0, 0, 2'b00, 3'b101, 5'd0, 5'd0, 5'd5);
      ZeroE = 1'b0;
      cyc(); cyc();
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({RegWriteM, RdM, ALUControlE, ALUSrcE, MemWriteM} !== 11'd0) begin
         bad++; $display("[TB] FAIL rst_pipe got=%h want=0", {RegWriteM, RdM, ALUControlE, ALUSrcE, MemWriteM});
      end
      total++;
      if ({RegWriteW, ResultSrcW, RdW, PCSrcE, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE} !== 17'd0) begin
         bad++; $display("[TB] FAIL rst_ctrl got=%h want=0",
                         {RegWriteW, ResultSrcW, RdW, PCSrcE, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE});
      end
      cyc();
      rst_n = 1'b1;
      #1;
      total++;
      if (ALUControlE !== 3'b000) begin
         bad++; $display("[TB] FAIL rst_hold got=%b want=000", ALUControlE);
      end
      cyc();
      total++;
      if (ALUControlE !== 3'b101 || RegWriteM !== 1'b0) begin
         bad++; $display("[TB] FAIL rst_first_e got=%b/%b want=101/0", ALUControlE, RegWriteM);
      end
      cyc();
      total++;
      if (RegWriteM !== 1'b1 || RdM !== 5'd5) begin
         bad++; $display("[TB] FAIL rst_second_m got=%b/%0d want=1/5", RegWriteM, RdM);
      end
   endtask

   task automatic test_alu_forward();
      flushPipe();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd1, 5'd2, 5'd5); cyc();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd5, 5'd7, 5'd6); #1;
      total++;
      if (StallF !== 1'b0) begin
         bad++; $display("[TB] FAIL alu_nostall got=%b want=0", StallF);
      end
      cyc();
      setD(0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0); #1;
      total++;
      if (ForwardAE !== 2'b10 || ForwardBE !== 2'b00) begin
         bad++; $display("[TB] FAIL alu_fwd_m got=%b/%b want=10/00", ForwardAE, ForwardBE);
      end
      flushPipe();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd1, 5'd2, 5'd5); cyc();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd1, 5'd2, 5'd9); cyc();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd5, 5'd7, 5'd6); cyc();
      setD(0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0); #1;
      total++;
      if (ForwardAE !== 2'b01 || ForwardBE !== 2'b00) begin
         bad++; $display("[TB] FAIL alu_fwd_w got=%b/%b want=01/00", ForwardAE, ForwardBE);
      end
      flushPipe();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd1, 5'd2, 5'd5); cyc();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd3, 5'd4, 5'd5); cyc();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd7, 5'd5, 5'd6); cyc();
      setD(0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0); #1;
      total++;
      if (ForwardBE !== 2'b10 || ForwardAE !== 2'b00) begin
         bad++; $display("[TB] FAIL alu_m_beats_w got=%b/%b want=10/00", ForwardBE, ForwardAE);
      end
   endtask

   task automatic test_load_use();
      flushPipe();
      setD(1, 0, 0, 1, 2'b01, 3'd0, 5'd1, 5'd0, 5'd5); cyc();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd3, 5'd5, 5'd6); #1;
      total++;
      if ({StallF, StallD, FlushE, FlushD} !== 4'b1110) begin
         bad++; $display("[TB] FAIL lu_stall got=%b want=1110", {StallF, StallD, FlushE, FlushD});
      end
      cyc(); #1;
      total++;
      if ({StallF, StallD, FlushE} !== 3'b000) begin
         bad++; $display("[TB] FAIL lu_one_cycle got=%b want=000", {StallF, StallD, FlushE});
      end
      cyc(); #1;
      total++;
      if (ForwardBE !== 2'b01 || ForwardAE !== 2'b00) begin
         bad++; $display("[TB] FAIL lu_fwd_w got=%b/%b want=01/00", ForwardBE, ForwardAE);
      end
      total++;
      if (RegWriteM !== 1'b0 || RdM !== 5'd0) begin
         bad++; $display("[TB] FAIL lu_bubble got=%b/%0d want=0/0", RegWriteM, RdM);
      end
   endtask

   task automatic test_x0();
      flushPipe();
      setD(1, 0, 0, 0, 2'b01, 3'd0, 5'd1, 5'd2, 5'd0); cyc();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd7); #1;
      total++;
      if (StallF !== 1'b0 || FlushE !== 1'b0) begin
         bad++; $display("[TB] FAIL x0_stall got=%b/%b want=0/0", StallF, FlushE);
      end
      cyc();
      setD(0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0); #1;
      total++;
      if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
         bad++; $display("[TB] FAIL x0_fwd got=%b/%b want=00/00", ForwardAE, ForwardBE);
      end
   endtask

   task automatic test_branch();
      flushPipe();
      setD(0, 0, 1, 0, 2'b00, 3'd1, 5'd1, 5'd2, 5'd0); cyc();
      setD(1, 1, 0, 0, 2'b00, 3'd0, 5'd3, 5'd4, 5'd8);
      ZeroE = 1'b1; #1;
      total++;
      if ({PCSrcE, FlushD, FlushE, StallF} !== 4'b1110) begin
         bad++; $display("[TB] FAIL br_taken got=%b want=1110", {PCSrcE, FlushD, FlushE, StallF});
      end
      cyc();
      ZeroE = 1'b0;
      setD(0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0); cyc(); #1;
      total++;
      if (RegWriteM !== 1'b0 || MemWriteM !== 1'b0) begin
         bad++; $display("[TB] FAIL br_bubble got=%b/%b want=0/0", RegWriteM, MemWriteM);
      end
      setD(0, 0, 1, 0, 2'b00, 3'd1, 5'd1, 5'd2, 5'd0); cyc();
      setD(1, 1, 0, 0, 2'b00, 3'd0, 5'd3, 5'd4, 5'd8); #1;
      total++;
      if ({PCSrcE, FlushD, FlushE} !== 3'b000) begin
         bad++; $display("[TB] FAIL br_not_taken got=%b want=000", {PCSrcE, FlushD, FlushE});
      end
      cyc();
      setD(0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0); cyc(); #1;
      total++;
      if (RegWriteM !== 1'b1 || MemWriteM !== 1'b1 || RdM !== 5'd8) begin
         bad++; $display("[TB] FAIL br_pass got=%b/%b/%0d want=1/1/8", RegWriteM, MemWriteM, RdM);
      end
   endtask

   task automatic test_sanitize_priority();
      flushPipe();
      setD(1, 0, 0, 0, 2'b10, 3'd0, 5'd0, 5'd0, 5'd3); cyc();
      setD(0, 1, 0, 1, 2'bxx, 3'd0, 5'd1, 5'd2, 5'd0); cyc();
      setD(0, 1, 0, 1, 2'b10, 3'd0, 5'd1, 5'd2, 5'd5); cyc();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd5, 5'd0, 5'd6); #1;
      total++;
      if (StallF !== 1'b0) begin
         bad++; $display("[TB] FAIL san_nostall got=%b want=0", StallF);
      end
      total++;
      if (ResultSrcW !== 2'b10) begin
         bad++; $display("[TB] FAIL san_writer got=%b want=10", ResultSrcW);
      end
      cyc(); #1;
      total++;
      if (ResultSrcW !== 2'b00) begin
         bad++; $display("[TB] FAIL san_x got=%b want=00", ResultSrcW);
      end
      cyc(); #1;
      total++;
      if (ResultSrcW !== 2'b00) begin
         bad++; $display("[TB] FAIL san_10 got=%b want=00", ResultSrcW);
      end
      flushPipe();
      setD(1, 0, 1, 0, 2'b01, 3'd0, 5'd1, 5'd2, 5'd5); cyc();
      setD(1, 0, 0, 0, 2'b00, 3'd0, 5'd5, 5'd0, 5'd6);
      ZeroE = 1'b1; #1;
      total++;
      if ({PCSrcE, FlushD, FlushE, StallF, StallD} !== 5'b11111) begin
         bad++; $display("[TB] FAIL prio got=%b want=11111", {PCSrcE, FlushD, FlushE, StallF, StallD});
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({PCSrcE, FlushD, FlushE, StallF, StallD} !== 5'b00000) begin
         bad++; $display("[TB] FAIL prio_reset got=%b want=00000", {PCSrcE, FlushD, FlushE, StallF, StallD});
      end
      cyc();
      rst_n = 1'b1;
      ZeroE = 1'b0;
   endtask

   function automatic logic [1:0] fwdSel(input logic [4:0] src, input instr_t m, input instr_t w);
      if (src != 0 && m.regWrite && m.rd == src) return 2'b10;
      if (src != 0 && w.regWrite && w.rd == src) return 2'b01;
      return 2'b00;
   endfunction

   // History holds the instructions occupying W, M, E (oldest first); a flushed slot is a zero record
   task automatic test_random();
      instr_t hist[$];
      instr_t e, m, w, inD;
      logic [27:0] got, want;
      logic pcsrc, lw;
      flushPipe();
      hist = {instr_t'(0), instr_t'(0), instr_t'(0)};
      for (int n = 0; n < 400; n++) begin
         inD.regWrite  = 1'($urandom);
         inD.resultSrc = 2'($urandom);
         inD.memWrite  = 1'($urandom);
         inD.branch    = ($urandom_range(0, 3) == 0);
         inD.aluSrc    = 1'($urandom);
         inD.aluCtl    = 3'($urandom);
         inD.rs1       = 5'($urandom_range(0, 3));
         inD.rs2       = 5'($urandom_range(0, 3));
         inD.rd        = 5'($urandom_range(0, 3));
         setD(inD.regWrite, inD.memWrite, inD.branch, inD.aluSrc, inD.resultSrc, inD.aluCtl,
              inD.rs1, inD.rs2, inD.rd);
         ZeroE = 1'($urandom);
         #1;
         w = hist[0]; m = hist[1]; e = hist[2];
         pcsrc = e.branch && ZeroE;
         lw = (e.resultSrc == 2'b01) && e.rd != 0 && (inD.rs1 == e.rd || inD.rs2 == e.rd);
         want = {e.aluSrc, e.aluCtl, m.memWrite, m.regWrite, m.rd, w.regWrite, w.resultSrc, w.rd,
                 pcsrc, fwdSel(e.rs1, m, w), fwdSel(e.rs2, m, w), lw, lw, pcsrc, lw | pcsrc};
         got = {ALUSrcE, ALUControlE, MemWriteM, RegWriteM, RdM, RegWriteW, ResultSrcW, RdW,
                PCSrcE, ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE};
         total++;
         if (got !== want) begin
            bad++; $display("[TB] FAIL rand_cycle%0d got=%h want=%h", n, got, want);
         end
         if (!inD.regWrite) inD.resultSrc = 2'b00;
         if (lw || pcsrc) inD = '0;
         void'(hist.pop_front());
         hist.push_back(inD);
         cyc();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      setD(0, 0, 0, 0, 2'b00, 3'd0, 5'd0, 5'd0, 5'd0);
      ZeroE = 1'b0;
      repeat (3) cyc();
      rst_n = 1'b1;
      test_reset();
      test_alu_forward();
      test_load_use();
      test_x0();
      test_branch();
      test_sanitize_priority();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
